// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and constants for the core/PIM data-bus arbiter.
// Rev 1.0
`default_nettype none

package dbus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CORE   = 2'd1;
  localparam state_t ST_PBURST = 2'd2;
  localparam state_t ST_PDONE  = 2'd3;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_PIM  = 1'b1
  } owner_t;

  localparam logic [3:0] BE_FULL    = 4'b1111;
  localparam int         WORD_BYTES = 4;

  function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_burst_ctr.sv
// dbus_burst_ctr: burst address / remaining-word counters with length clamp.
// Rev 1.0
`default_nettype none

module dbus_burst_ctr
  import dbus_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] base_addr,
  input  logic [4:0]  len,
  output logic [31:0] addr,
  output logic        last_word,
  output logic        len_zero
);

  localparam logic [4:0] MAX_LEN = 5'(BURST_MAX);

  logic [4:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base_addr;
      remaining <= clamp_len(len, MAX_LEN);
    end else if (step) begin
      // Address wraps naturally modulo 2^32.
      addr      <= addr + 32'(WORD_BYTES);
      remaining <= remaining - 5'd1;
    end
  end

  assign last_word = (remaining == 5'd1);
  assign len_zero  = (len == 5'd0);

endmodule

`default_nettype wire

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin arbiter sharing the data SRAM between core and PIM bursts.
// Rev 1.0
`default_nettype none

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int BURST_MAX = 16
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        C_RD,
  input  logic        C_WR,
  input  logic [31:0] C_ADDR,
  input  logic [3:0]  C_BE,
  input  logic [31:0] C_DATAO,
  output logic [31:0] C_DATAI,
  output logic        C_HLT,
  input  logic        P_REQ,
  input  logic        P_WR,
  input  logic [31:0] P_ADDR,
  input  logic [4:0]  P_LEN,
  input  logic [31:0] P_WDATA,
  output logic        P_GNT,
  output logic        P_WNEXT,
  output logic        P_RVALID,
  output logic [31:0] P_RDATA,
  output logic        P_DONE,
  output logic        M_RD,
  output logic        M_WR,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_BE,
  output logic [31:0] M_DATAO,
  input  logic [31:0] M_DATAI,
  input  logic        M_ACK
);

  state_t      state;
  state_t      state_nxt;
  owner_t      last_owner;
  logic        dir;
  logic        core_req;
  logic        core_win;
  logic        pim_win;
  logic        ack_core;
  logic        ack_burst;
  logic [31:0] burst_addr;
  logic        last_word;
  logic        len_zero;

  assign core_req  = C_RD | C_WR;
  // On contention the side that did not own the bus last time wins.
  assign core_win  = (state == ST_IDLE) & core_req & (~P_REQ | (last_owner == OWN_PIM));
  assign pim_win   = (state == ST_IDLE) & P_REQ & ~core_win;
  assign ack_core  = (state == ST_CORE) & M_ACK;
  assign ack_burst = (state == ST_PBURST) & M_ACK;

  dbus_burst_ctr #(
    .BURST_MAX (BURST_MAX)
  ) u_ctr (
    .clk       (CLK),
    .rst       (RES),
    .load      (pim_win),
    .step      (ack_burst),
    .base_addr (P_ADDR),
    .len       (P_LEN),
    .addr      (burst_addr),
    .last_word (last_word),
    .len_zero  (len_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (core_win)     state_nxt = ST_CORE;
        else if (pim_win) state_nxt = len_zero ? ST_PDONE : ST_PBURST;
      end
      ST_CORE:   if (M_ACK) state_nxt = ST_IDLE;
      ST_PBURST: if (M_ACK && last_word) state_nxt = ST_PDONE;
      ST_PDONE:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state      <= ST_IDLE;
      last_owner <= OWN_PIM;
      dir        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pim_win)  dir        <= P_WR;
      if (ack_core) last_owner <= OWN_CORE;
      else if (state == ST_PDONE) last_owner <= OWN_PIM;
    end
  end

  always_comb begin
    M_RD    = 1'b0;
    M_WR    = 1'b0;
    M_ADDR  = '0;
    M_BE    = '0;
    M_DATAO = '0;
    if (!RES) begin
      case (state)
        ST_CORE: begin
          M_RD    = C_RD;
          M_WR    = C_WR;
          M_ADDR  = C_ADDR;
          M_BE    = C_BE;
          M_DATAO = C_DATAO;
        end
        ST_PBURST: begin
          M_RD    = ~dir;
          M_WR    = dir;
          M_ADDR  = burst_addr;
          M_BE    = BE_FULL;
          M_DATAO = P_WDATA;
        end
        default: ;
      endcase
    end
  end

  assign C_HLT    = ~RES & core_req & ~ack_core;
  assign P_GNT    = ~RES & pim_win;
  assign P_DONE   = ~RES & (state == ST_PDONE);
  assign P_RVALID = ~RES & ack_burst & ~dir;
  assign P_WNEXT  = ~RES & ack_burst & dir;
  assign C_DATAI  = M_DATAI;
  assign P_RDATA  = M_DATAI;

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: vector table, directed corner sequences and random traffic vs a memory model.
// Rev 1.0
`default_nettype none

module tb_dbus_arbiter;

  logic        CLK = 1'b0;
  logic        RES;
  logic        C_RD, C_WR;
  logic [31:0] C_ADDR, C_DATAO, C_DATAI;
  logic [3:0]  C_BE;
  logic        C_HLT;
  logic        P_REQ, P_WR;
  logic [31:0] P_ADDR, P_WDATA, P_RDATA;
  logic [4:0]  P_LEN;
  logic        P_GNT, P_WNEXT, P_RVALID, P_DONE;
  logic        M_RD, M_WR, M_ACK;
  logic [31:0] M_ADDR, M_DATAO, M_DATAI;
  logic [3:0]  M_BE;

  int checks = 0;
  int errors = 0;
  int core_done = 0;
  int fixed_wait = 0;
  bit rand_mode = 1'b0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always #5 CLK = ~CLK;

  dbus_arbiter #(.BURST_MAX(16)) dut (
    .CLK(CLK), .RES(RES),
    .C_RD(C_RD), .C_WR(C_WR), .C_ADDR(C_ADDR), .C_BE(C_BE), .C_DATAO(C_DATAO),
    .C_DATAI(C_DATAI), .C_HLT(C_HLT),
    .P_REQ(P_REQ), .P_WR(P_WR), .P_ADDR(P_ADDR), .P_LEN(P_LEN), .P_WDATA(P_WDATA),
    .P_GNT(P_GNT), .P_WNEXT(P_WNEXT), .P_RVALID(P_RVALID), .P_RDATA(P_RDATA), .P_DONE(P_DONE),
    .M_RD(M_RD), .M_WR(M_WR), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DATAO(M_DATAO),
    .M_DATAI(M_DATAI), .M_ACK(M_ACK)
  );

  function automatic logic [31:0] init_word(input int i);
    return {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
  endfunction

  function automatic logic [31:0] wd(input int b, input int k);
    return 32'hC0DE0000 | (32'(b) << 8) | 32'(k);
  endfunction

  // SRAM model: acks each access after a programmable number of wait cycles.
  initial begin
    int wcnt;
    int need;
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    M_ACK = 1'b0; M_DATAI = '0; wcnt = 0; need = 0;
    forever begin
      @(posedge CLK); #2;
      if (!RES && (M_RD || M_WR)) begin
        if (wcnt >= need) begin
          M_ACK = 1'b1;
          if (M_WR)
            for (int bb = 0; bb < 4; bb++)
              if (M_BE[bb]) mem[M_ADDR[9:2]][8*bb +: 8] = M_DATAO[8*bb +: 8];
          wcnt = 0;
          need = rand_mode ? int'($urandom_range(0, 3)) : fixed_wait;
        end else begin
          M_ACK = 1'b0;
          wcnt++;
        end
      end else begin
        M_ACK = 1'b0;
        wcnt = 0;
        need = rand_mode ? int'($urandom_range(0, 3)) : fixed_wait;
      end
      M_DATAI = mem[M_ADDR[9:2]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+7.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    #6;
  endtask

  task automatic clear_inputs();
    C_RD = 0; C_WR = 0; C_ADDR = '0; C_BE = '0; C_DATAO = '0;
    P_REQ = 0; P_WR = 0; P_ADDR = '0; P_LEN = '0; P_WDATA = '0;
  endtask

  task automatic do_reset();
    RES = 1'b1;
    clear_inputs();
    smp();
    tick();
    RES = 1'b0;
  endtask

  task automatic wait_core(output int stalls, output bit ok);
    stalls = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      smp();
      if (!C_HLT) begin ok = 1'b1; break; end
      stalls++;
      tick();
    end
    if (!ok) smp();
  endtask

  task automatic core_agent(input int n);
    int stalls; bit ok, wr; logic [7:0] idx; logic [3:0] be; logic [31:0] data;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      wr = 1'($urandom_range(0, 1));
      idx = 8'($urandom_range(0, 255));
      be = 4'($urandom_range(1, 15));
      data = $urandom;
      C_RD = ~wr; C_WR = wr; C_ADDR = {22'd0, idx, 2'b00}; C_BE = be; C_DATAO = data;
      wait_core(stalls, ok);
      chk("core_timeout", 32'(ok), 32'd1);
      if (ok) begin
        if (!wr) chk("core_rd_data", C_DATAI, ref_mem[idx]);
        else
          for (int bb = 0; bb < 4; bb++)
            if (be[bb]) ref_mem[idx][8*bb +: 8] = data[8*bb +: 8];
        core_done++;
      end
      tick();
      C_RD = 0; C_WR = 0;
    end
  endtask

  task automatic engine_agent(input int n);
    int c0, cd, k, exp_n; bit got, wr; logic [31:0] base, ea; logic [4:0] len;
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, 4)) tick();
      wr = 1'($urandom_range(0, 1));
      len = 5'($urandom_range(0, 31));
      base = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      P_REQ = 1; P_WR = wr; P_ADDR = base; P_LEN = len; P_WDATA = wd(b, 0);
      c0 = core_done; got = 0;
      for (int i = 0; i < 300; i++) begin
        smp();
        if (P_GNT) begin got = 1; break; end
        tick();
      end
      if (!got) smp();
      chk("pim_grant_timeout", 32'(got), 32'd1);
      chk("pim_wait_gt_one_core", 32'((core_done - c0) > 1), 32'd0);
      tick();
      P_REQ = 0;
      if (!got) continue;
      k = 0; cd = core_done; got = 0;
      exp_n = (len > 5'd16) ? 16 : int'(len);
      for (int i = 0; i < 500; i++) begin
        smp();
        if (P_DONE) begin got = 1; break; end
        if (P_RVALID || P_WNEXT) begin
          ea = base + 32'(4 * k);
          chk("burst_addr", M_ADDR, ea);
          chk("burst_dir", 32'(P_WNEXT), 32'(wr));
          if (!wr) chk("burst_rdata", P_RDATA, ref_mem[ea[9:2]]);
          else ref_mem[ea[9:2]] = wd(b, k);
          k++;
        end
        tick();
        if (wr) P_WDATA = wd(b, k);
      end
      chk("burst_done_timeout", 32'(got), 32'd1);
      chk("burst_words", 32'(k), 32'(exp_n));
      chk("burst_preempted", 32'(core_done - cd), 32'd0);
      tick();
    end
  endtask

  typedef struct {
    logic       rst, crd, cwr, preq;
    logic [4:0] plen;
    logic       hlt, gnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int stalls, cnt, nmis; bit ok, seen;

    // IDLE decode straight after reset (core owns the first contention).
    vecs[0] = '{1, 1, 0, 1, 5'd4, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 5'd0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 5'd0, 1, 0};
    vecs[3] = '{0, 0, 1, 0, 5'd0, 1, 0};
    vecs[4] = '{0, 0, 0, 1, 5'd4, 0, 1};
    vecs[5] = '{0, 1, 0, 1, 5'd4, 1, 0};
    vecs[6] = '{0, 0, 1, 1, 5'd0, 1, 0};
    vecs[7] = '{0, 0, 0, 1, 5'd0, 0, 1};

    RES = 1'b1;
    clear_inputs();
    tick();
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst) RES = 1'b1;
      else do_reset();
      C_RD = vecs[v].crd; C_WR = vecs[v].cwr; P_REQ = vecs[v].preq;
      P_LEN = vecs[v].plen; C_ADDR = 32'h40; P_ADDR = 32'h80;
      smp();
      chk($sformatf("vec%0d_hlt", v), 32'(C_HLT), 32'(vecs[v].hlt));
      chk($sformatf("vec%0d_gnt", v), 32'(P_GNT), 32'(vecs[v].gnt));
      chk($sformatf("vec%0d_strobe", v), 32'(M_RD | M_WR | P_DONE), 32'd0);
      tick();
    end

    // Core load with two wait states.
    do_reset();
    fixed_wait = 2;
    C_RD = 1; C_ADDR = 32'h100; C_BE = 4'hF;
    wait_core(stalls, ok);
    chk("lw_complete", 32'(ok), 32'd1);
    chk("lw_hlt_cycles", 32'(stalls), 32'd3);
    chk("lw_data", C_DATAI, init_word(32'h40));
    chk("lw_maddr", M_ADDR, 32'h100);
    tick();
    C_RD = 0; fixed_wait = 0;
    smp();
    chk("lw_idle_strobe", 32'(M_RD | M_WR | C_HLT), 32'd0);
    tick();

    // Zero-wait read burst of four words.
    do_reset();
    P_REQ = 1; P_WR = 0; P_ADDR = 32'h200; P_LEN = 5'd4;
    smp();
    chk("rb_gnt", 32'(P_GNT), 32'd1);
    tick();
    P_REQ = 0; P_ADDR = '0; P_LEN = '0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("rb_addr", M_ADDR, 32'h200 + 32'(4 * k));
      chk("rb_rvalid", 32'(P_RVALID & M_RD), 32'd1);
      chk("rb_rdata", P_RDATA, init_word(32'h80 + k));
      tick();
    end
    smp();
    chk("rb_done", 32'(P_DONE), 32'd1);
    chk("rb_done_strobe", 32'(M_RD | M_WR), 32'd0);
    tick();
    smp();
    chk("rb_done_once", 32'(P_DONE), 32'd0);
    tick();

    // Simultaneous requests alternate ownership.
    do_reset();
    C_RD = 1; C_ADDR = 32'h10; C_BE = 4'hF;
    P_REQ = 1; P_WR = 0; P_ADDR = 32'h40; P_LEN = 5'd1;
    smp(); chk("sim_core_first", 32'({C_HLT, P_GNT}), 32'b10); tick();
    smp(); chk("sim_core_access", 32'({M_RD, C_HLT}), 32'b10); tick();
    smp(); chk("sim_pim_next", 32'({C_HLT, P_GNT}), 32'b11); tick();
    smp(); chk("sim_pim_word", 32'({P_RVALID, M_ADDR[7:0]}), {23'd0, 1'b1, 8'h40}); tick();
    smp(); chk("sim_pim_done", 32'({P_DONE, P_GNT}), 32'b10); tick();
    smp(); chk("sim_core_again", 32'({C_HLT, P_GNT}), 32'b10); tick();
    smp(); chk("sim_core_addr", M_ADDR, 32'h10); tick();
    smp(); chk("sim_pim_again", 32'(P_GNT), 32'd1); tick();
    clear_inputs();

    // Zero-length burst: grant then done, no memory access.
    do_reset();
    P_REQ = 1; P_LEN = 5'd0; P_ADDR = 32'h60;
    smp(); chk("len0_gnt", 32'(P_GNT), 32'd1); tick();
    P_REQ = 0;
    smp();
    chk("len0_done", 32'(P_DONE), 32'd1);
    chk("len0_no_access", 32'(M_RD | M_WR), 32'd0);
    tick();
    smp(); chk("len0_done_once", 32'(P_DONE), 32'd0); tick();

    // Over-long burst is clamped to sixteen words.
    do_reset();
    P_REQ = 1; P_WR = 0; P_LEN = 5'd31; P_ADDR = 32'h300;
    smp(); chk("len31_gnt", 32'(P_GNT), 32'd1); tick();
    P_REQ = 0; cnt = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      smp();
      if (P_DONE) begin seen = 1; break; end
      if (P_RVALID) cnt++;
      tick();
    end
    chk("len31_done", 32'(seen), 32'd1);
    chk("len31_words", 32'(cnt), 32'd16);
    tick();

    // Write burst wrapping the top of the address space.
    do_reset();
    P_REQ = 1; P_WR = 1; P_ADDR = 32'hFFFF_FFF8; P_LEN = 5'd3; P_WDATA = wd(99, 0);
    smp(); chk("wb_gnt", 32'(P_GNT), 32'd1); tick();
    P_REQ = 0;
    for (int k = 0; k < 3; k++) begin
      P_WDATA = wd(99, k);
      smp();
      chk("wb_addr", M_ADDR, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("wb_wnext", 32'({P_WNEXT, M_WR, P_RVALID}), 32'b110);
      tick();
    end
    smp(); chk("wb_done", 32'(P_DONE), 32'd1); tick();
    chk("wb_mem0", mem[8'hFE], wd(99, 0));
    chk("wb_mem1", mem[8'hFF], wd(99, 1));
    chk("wb_mem2", mem[8'h00], wd(99, 2));

    // Reset in the middle of an eight-word burst.
    do_reset();
    P_REQ = 1; P_WR = 0; P_ADDR = 32'h280; P_LEN = 5'd8;
    smp(); tick();
    P_REQ = 0;
    smp(); chk("rst_word1", 32'(P_RVALID), 32'd1); tick();
    RES = 1;
    smp(); chk("rst_during", 32'({M_RD, M_WR, P_RVALID, P_DONE, P_GNT}), 32'd0); tick();
    RES = 0;
    for (int i = 0; i < 4; i++) begin
      smp(); chk("rst_after", 32'({M_RD, M_WR, P_RVALID, P_DONE}), 32'd0); tick();
    end
    C_RD = 1; C_ADDR = 32'h104; C_BE = 4'hF;
    wait_core(stalls, ok);
    chk("rst_lw_complete", 32'(ok), 32'd1);
    chk("rst_lw_stalls", 32'(stalls), 32'd1);
    chk("rst_lw_data", C_DATAI, init_word(32'h41));
    tick();
    C_RD = 0;

    // Random concurrent traffic against a transaction-level memory model.
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    rand_mode = 1'b1;
    do_reset();
    fork
      core_agent(40);
      engine_agent(15);
    join
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("final_mem_mismatches", 32'(nmis), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
